fifomem_wr_arbiter: RTL and testbench

// - Round-robin arbiter sharing the single write port of a fifomem-style dual-port RAM among NREQ requesters.
// - Grants one requester a burst of up to MAXBURST beats.
// - Drives w_en/w_data toward the memory write side and honours w_full backpressure.
// - Sits in the write clock domain, between producer clients and the FIFO write-pointer/memory logic.

---
 rtl/fifomem_wr_arbiter.sv | 157 +++++++++++++++
 tb/tb_fifomem_wr_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifomem_wr_arbiter.sv
// fifomem_wr_arbiter
// Round-robin arbiter that shares the single write port of a fifomem-style
// dual-port RAM among NREQ producers. A grant lasts for at most MAXBURST
// accepted beats, and the arbiter honours w_full backpressure.
//
// Ports:
//   w_clk        write-domain clock; all logic runs on the rising edge
//   w_rst        synchronous reset, active-high
//   req_valid    per-requester beat valid
//   req_last     per-requester end-of-burst marker, qualified by req_valid
//   req_data     packed beats; requester i is at [i*DATASIZE +: DATASIZE]
//   req_ready    one-hot-or-zero accept toward the requesters
//   w_full       memory full; no write issues while this is high
//   w_en, w_data write strobe and write data toward the memory
//   grant_id     current owner; valid while busy is high
//   busy         a burst is in progress
//
// Optional build macro FIFOMEM_ARB_STATS_EN adds these outputs:
//   stall_cnt    saturating count of owner-valid cycles stalled by w_full
//   beats_total  wrapping count of w_en pulses
module fifomem_wr_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned DATASIZE = 8,
  parameter int unsigned MAXBURST = 4,
  localparam int unsigned IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     w_clk,
  input  logic                     w_rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_last,
  input  logic [NREQ*DATASIZE-1:0] req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     w_full,
  output logic                     w_en,
  output logic [DATASIZE-1:0]      w_data,
  output logic [IDW-1:0]           grant_id,
  output logic                     busy
`ifdef FIFOMEM_ARB_STATS_EN
  ,
  output logic [15:0]              stall_cnt,
  output logic [31:0]              beats_total
`endif
);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e          state_q;
  logic [IDW-1:0]  owner_q;
  logic [IDW-1:0]  rr_ptr_q;
  logic [7:0]      beat_cnt_q;

  logic [DATASIZE-1:0] data_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign data_arr[gi] = req_data[gi*DATASIZE +: DATASIZE];
  end

  logic in_burst, owner_valid, accept, last_hit, cap_hit, burst_end;

  assign in_burst    = (state_q == StBurst);
  assign owner_valid = req_valid[owner_q];
  assign accept      = in_burst && owner_valid && !w_full;
  assign last_hit    = accept && req_last[owner_q];
  assign cap_hit     = accept && (({1'b0, beat_cnt_q} + 9'd1) == 9'(MAXBURST));
  // A burst must be contiguous: an owner gap while the memory can take data ends it.
  assign burst_end   = last_hit || cap_hit || (in_burst && !owner_valid && !w_full);

  // Rotating priority search starting just after the base index. In IDLE the base
  // is rr_ptr; on a burst end it is the outgoing owner, which becomes rr_ptr.
  logic [NREQ-1:0] arb_cand;
  logic [IDW-1:0]  arb_base;
  logic [IDW-1:0]  arb_idx;
  logic [IDW-1:0]  arb_pick;
  logic            arb_found;

  always_comb begin
    arb_cand  = req_valid;
    // The valid that carried the final (last-marked) beat was just consumed, so
    // it is not a request for a new burst. After a MAXBURST cut the owner still
    // competes, at lowest priority.
    if (last_hit) begin
      arb_cand[owner_q] = 1'b0;
    end
    arb_base  = in_burst ? owner_q : rr_ptr_q;
    arb_idx   = '0;
    arb_pick  = '0;
    arb_found = 1'b0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      arb_idx = IDW'((32'(arb_base) + i) % NREQ);
      if (!arb_found && arb_cand[arb_idx]) begin
        arb_found = 1'b1;
        arb_pick  = arb_idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (in_burst) begin
      req_ready[owner_q] = !w_full;
    end
  end

  assign w_en     = accept;
  assign w_data   = in_burst ? data_arr[owner_q] : '0;
  assign grant_id = owner_q;
  assign busy     = in_burst;

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state_q    <= StIdle;
      owner_q    <= '0;
      rr_ptr_q   <= IDW'(NREQ - 1);
      beat_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (arb_found) begin
            owner_q <= arb_pick;
            state_q <= StBurst;
          end
        end
        StBurst: begin
          if (burst_end) begin
            rr_ptr_q   <= owner_q;
            beat_cnt_q <= '0;
            if (arb_found) begin
              owner_q <= arb_pick;
            end else begin
              state_q <= StIdle;
            end
          end else if (accept) begin
            beat_cnt_q <= beat_cnt_q + 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef FIFOMEM_ARB_STATS_EN
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      stall_cnt   <= '0;
      beats_total <= '0;
    end else begin
      if (in_burst && owner_valid && w_full && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (w_en) begin
        beats_total <= beats_total + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifomem_wr_arbiter.sv
// Testbench for fifomem_wr_arbiter: directed scenarios plus randomized traffic,
// checked against a behavioural model of the arbitration rules.
module tb_fifomem_wr_arbiter;

  localparam int NREQ     = 4;
  localparam int DATASIZE = 8;
  localparam int MAXBURST = 4;

  logic                     w_clk = 1'b0;
  logic                     w_rst;
  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0]          req_last;
  logic [NREQ*DATASIZE-1:0] req_data;
  logic [NREQ-1:0]          req_ready;
  logic                     w_full;
  logic                     w_en;
  logic [DATASIZE-1:0]      w_data;
  logic [1:0]               grant_id;
  logic                     busy;
`ifdef FIFOMEM_ARB_STATS_EN
  logic [15:0]              stall_cnt;
  logic [31:0]              beats_total;
`endif

  int checks = 0;
  int errors = 0;

  fifomem_wr_arbiter #(
    .NREQ    (NREQ),
    .DATASIZE(DATASIZE),
    .MAXBURST(MAXBURST)
  ) dut (
    .w_clk    (w_clk),
    .w_rst    (w_rst),
    .req_valid(req_valid),
    .req_last (req_last),
    .req_data (req_data),
    .req_ready(req_ready),
    .w_full   (w_full),
    .w_en     (w_en),
    .w_data   (w_data),
    .grant_id (grant_id),
    .busy     (busy)
`ifdef FIFOMEM_ARB_STATS_EN
    ,
    .stall_cnt  (stall_cnt),
    .beats_total(beats_total)
`endif
  );

  always #5 w_clk = ~w_clk;

  // Behavioural model: who owns the port, who won last, beats granted so far.
  bit          m_busy   = 1'b0;
  int          m_owner  = 0;
  int          m_last_w = NREQ - 1;
  int          m_beats  = 0;
  int unsigned m_stall  = 0;
  int unsigned m_total  = 0;

  logic [NREQ-1:0]     exp_ready;
  logic                exp_wen;
  logic [DATASIZE-1:0] exp_data;

  always_comb begin
    exp_ready = '0;
    exp_wen   = 1'b0;
    exp_data  = '0;
    if (m_busy) begin
      exp_ready[m_owner] = !w_full;
      exp_wen            = req_valid[m_owner] && !w_full;
      exp_data           = req_data[m_owner*DATASIZE +: DATASIZE];
    end
  end

  // First requester in cand found walking forward from just after 'after'.
  function automatic int next_after(int after, logic [NREQ-1:0] cand);
    for (int i = 1; i <= NREQ; i++) begin
      if (cand[(after + i) % NREQ]) return (after + i) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_step();
    logic [NREQ-1:0] cand;
    int nxt;
    bit done, used_last;
    if (w_rst) begin
      m_busy = 1'b0; m_owner = 0; m_last_w = NREQ - 1; m_beats = 0;
      m_stall = 0; m_total = 0;
      return;
    end
    if (m_busy && req_valid[m_owner] && w_full && m_stall < 32'hFFFF) m_stall++;
    if (m_busy && req_valid[m_owner] && !w_full) m_total++;
    if (!m_busy) begin
      nxt = next_after(m_last_w, req_valid);
      if (nxt >= 0) begin
        m_busy  = 1'b1;
        m_owner = nxt;
      end
    end else if (!w_full) begin
      done = 1'b0; used_last = 1'b0;
      if (req_valid[m_owner]) begin
        m_beats++;
        if (req_last[m_owner]) begin
          done = 1'b1; used_last = 1'b1;
        end else if (m_beats == MAXBURST) begin
          done = 1'b1;
        end
      end else begin
        done = 1'b1;
      end
      if (done) begin
        m_last_w = m_owner;
        m_beats  = 0;
        cand     = req_valid;
        if (used_last) cand[m_owner] = 1'b0;
        nxt = next_after(m_last_w, cand);
        if (nxt >= 0) m_owner = nxt;
        else m_busy = 1'b0;
      end
    end
  endtask

  // Advance one clock: model follows the edge, then return at the falling edge.
  task automatic tick();
    @(posedge w_clk);
    model_step();
    @(negedge w_clk);
  endtask

  task automatic drain();
    int n = 0;
    req_valid = '0; req_last = '0; w_full = 1'b0;
    while (busy === 1'b1 && n < 8) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL drain: busy=%b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic test_reset();
    w_rst = 1'b1; req_valid = 4'hF; req_last = '0; w_full = 1'b0; req_data = $urandom;
    tick(); tick();
    #1;
    checks++;
    if (req_ready !== 4'h0 || w_en !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b w_en=%b busy=%b, required 0000 0 0",
               req_ready, w_en, busy);
    end
    checks++;
    if (grant_id !== 2'd0 || w_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_grant_data: grant=%0d w_data=%h, required 0 00", grant_id, w_data);
    end
    w_rst = 1'b0;
    tick();
    #1;
    checks++;
    if (busy !== 1'b1 || grant_id !== 2'd0 || req_ready !== 4'b0001 || w_en !== 1'b1) begin
      errors++;
      $display("FAIL first_grant: busy=%b grant=%0d ready=%b w_en=%b, required 1 0 0001 1",
               busy, grant_id, req_ready, w_en);
    end
    drain();
  endtask

  task automatic test_fairness();
    w_rst = 1'b1; tick(); w_rst = 1'b0;
    req_valid = 4'hF; req_last = '0; w_full = 1'b0; req_data = $urandom;
    tick();
    for (int k = 0; k < 20; k++) begin
      req_data = $urandom;
      #1;
      checks++;
      if (busy !== 1'b1 || w_en !== 1'b1 || grant_id !== 2'((k / MAXBURST) % NREQ) ||
          w_data !== req_data[((k / MAXBURST) % NREQ)*DATASIZE +: DATASIZE]) begin
        errors++;
        $display("FAIL fairness beat %0d: busy=%b w_en=%b grant=%0d data=%h, required 1 1 %0d",
                 k, busy, w_en, grant_id, w_data, (k / MAXBURST) % NREQ);
      end
      checks++;
      if ({req_ready, w_en, w_data} !== {exp_ready, exp_wen, exp_data}) begin
        errors++;
        $display("FAIL fairness_model %0d: ready=%b w_en=%b data=%h, required %b %b %h",
                 k, req_ready, w_en, w_data, exp_ready, exp_wen, exp_data);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_last();
    req_valid = 4'b0100; req_last = '0; w_full = 1'b0;
    req_data = $urandom; req_data[23:16] = 8'hA1;
    tick();
    #1;
    checks++;
    if (busy !== 1'b1 || grant_id !== 2'd2 || w_en !== 1'b1 || w_data !== 8'hA1) begin
      errors++;
      $display("FAIL last_beat1: busy=%b grant=%0d w_en=%b data=%h, required 1 2 1 a1",
               busy, grant_id, w_en, w_data);
    end
    tick();
    req_data[23:16] = 8'hA2; req_last = 4'b0100;
    #1;
    checks++;
    if (w_en !== 1'b1 || w_data !== 8'hA2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL last_beat2: w_en=%b data=%h busy=%b, required 1 a2 1", w_en, w_data, busy);
    end
    tick();
    req_valid = '0; req_last = '0;
    #1;
    checks++;
    if (busy !== 1'b0 || w_en !== 1'b0 || w_data !== 8'h00) begin
      errors++;
      $display("FAIL last_release: busy=%b w_en=%b data=%h, required 0 0 00", busy, w_en, w_data);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [7:0] held;
    req_valid = 4'b0010; req_last = '0; w_full = 1'b0; req_data = $urandom;
    tick();
    tick();
    held = req_data[15:8];
    w_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (w_en !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b1 || grant_id !== 2'd1) begin
        errors++;
        $display("FAIL bp_stall %0d: w_en=%b ready=%b busy=%b grant=%0d, required 0 0000 1 1",
                 k, w_en, req_ready, busy, grant_id);
      end
      tick();
    end
    // Requester 2 joins; owner 1 must still get exactly 3 more beats (4 total).
    w_full = 1'b0; req_valid = 4'b0110;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (w_en !== 1'b1 || grant_id !== ((k < 3) ? 2'd1 : 2'd2) ||
          (k == 0 && w_data !== held)) begin
        errors++;
        $display("FAIL bp_resume %0d: w_en=%b grant=%0d data=%h, required 1 %0d",
                 k, w_en, grant_id, w_data, (k < 3) ? 1 : 2);
      end
      checks++;
      if ({req_ready, w_en, w_data} !== {exp_ready, exp_wen, exp_data}) begin
        errors++;
        $display("FAIL bp_model %0d: ready=%b w_en=%b data=%h, required %b %b %h",
                 k, req_ready, w_en, w_data, exp_ready, exp_wen, exp_data);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_dropout();
    req_valid = 4'b1000; req_last = '0; w_full = 1'b0; req_data = $urandom;
    tick();
    #1;
    checks++;
    if (busy !== 1'b1 || grant_id !== 2'd3 || w_en !== 1'b1) begin
      errors++;
      $display("FAIL dropout_grant3: busy=%b grant=%0d w_en=%b, required 1 3 1",
               busy, grant_id, w_en);
    end
    tick();
    req_valid = 4'b0001;
    #1;
    checks++;
    if (w_en !== 1'b0 || busy !== 1'b1 || grant_id !== 2'd3) begin
      errors++;
      $display("FAIL dropout_gap: w_en=%b busy=%b grant=%0d, required 0 1 3", w_en, busy, grant_id);
    end
    tick();
    #1;
    checks++;
    if (busy !== 1'b1 || grant_id !== 2'd0 || w_en !== 1'b1) begin
      errors++;
      $display("FAIL dropout_handoff: busy=%b grant=%0d w_en=%b, required 1 0 1",
               busy, grant_id, w_en);
    end
    drain();
  endtask

`ifdef FIFOMEM_ARB_STATS_EN
  task automatic test_stats();
    w_rst = 1'b1; tick(); w_rst = 1'b0;
    #1;
    checks++;
    if (stall_cnt !== 16'd0 || beats_total !== 32'd0) begin
      errors++;
      $display("FAIL stats_reset: stall=%0d beats=%0d, required 0 0", stall_cnt, beats_total);
    end
    req_valid = 4'b0001; req_last = '0; w_full = 1'b1; req_data = $urandom;
    tick();
    repeat (5) tick();
    w_full = 1'b0;
    repeat (10) tick();
    req_valid = '0;
    #1;
    checks++;
    if (stall_cnt !== 16'd5 || beats_total !== 32'd10) begin
      errors++;
      $display("FAIL stats_count: stall=%0d beats=%0d, required 5 10", stall_cnt, beats_total);
    end
    drain();
    w_rst = 1'b1; tick(); w_rst = 1'b0;
    #1;
    checks++;
    if (stall_cnt !== 16'd0 || beats_total !== 32'd0) begin
      errors++;
      $display("FAIL stats_clear: stall=%0d beats=%0d, required 0 0", stall_cnt, beats_total);
    end
  endtask
`endif

  task automatic test_random();
    req_valid = '0; req_last = '0; w_full = 1'b0;
    for (int c = 0; c < 800; c++) begin
      w_rst = ($urandom_range(0, 149) == 0);
      for (int b = 0; b < NREQ; b++) begin
        if ($urandom_range(0, 3) == 0) req_valid[b] = ~req_valid[b];
      end
      req_last = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      w_full   = ($urandom_range(0, 3) == 0);
      req_data = $urandom;
      #1;
      checks++;
      if ({busy, req_ready, w_en, w_data} !== {m_busy, exp_ready, exp_wen, exp_data} ||
          (m_busy && grant_id !== 2'(m_owner))) begin
        errors++;
        $display("FAIL random cyc %0d: busy=%b ready=%b w_en=%b data=%h grant=%0d, required %b %b %b %h %0d",
                 c, busy, req_ready, w_en, w_data, grant_id, m_busy, exp_ready, exp_wen,
                 exp_data, m_owner);
      end
      checks++;
      if ($countones(req_ready) > 1 || (w_en && w_full)) begin
        errors++;
        $display("FAIL random_invariant cyc %0d: ready=%b w_en=%b w_full=%b", c, req_ready,
                 w_en, w_full);
      end
`ifdef FIFOMEM_ARB_STATS_EN
      checks++;
      if (stall_cnt !== 16'(m_stall) || beats_total !== m_total) begin
        errors++;
        $display("FAIL random_stats cyc %0d: stall=%0d beats=%0d, required %0d %0d", c,
                 stall_cnt, beats_total, m_stall, m_total);
      end
`endif
      tick();
    end
    w_rst = 1'b0;
    drain();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    w_rst = 1'b1; req_valid = '0; req_last = '0; w_full = 1'b0; req_data = '0;
    test_reset();
    test_fairness();
    test_last();
    test_backpressure();
    test_dropout();
`ifdef FIFOMEM_ARB_STATS_EN
    test_stats();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
